// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues single-outstanding word
// reads and buffers returned instructions in a small prefetch queue for decode.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(QUEUE_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_ent_t;

  fq_ent_t       q [QUEUE_DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          outstanding;
  logic          stale;
  logic          pop;
  logic          resp;
  logic          push;
  logic [AW+1:0] occ;

  assign id_valid = (count != '0);
  assign pop      = id_valid & id_ready;
  assign resp     = imem_rvalid & outstanding;
  assign push     = resp & ~stale & ~redirect_valid;

  // Slots already claimed once this cycle's pop retires; an issue needs one free.
  assign occ = {1'b0, count}
             + {{(AW+1){1'b0}}, outstanding}
             - {{(AW+1){1'b0}}, pop};

  assign imem_req = rst & ~redirect_valid
                  & (~outstanding | imem_rvalid)
                  & (occ < DEPTH_W);

  assign imem_addr = fetch_pc;
  assign id_pc     = id_valid ? q[head].pc   : '0;
  assign id_inst   = id_valid ? q[head].inst : NOP;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      stale       <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= {redirect_pc[31:2], 2'b00};
      // A response landing on the redirect edge is simply dropped.
      outstanding <= outstanding & ~imem_rvalid;
      stale       <= outstanding & ~imem_rvalid;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case (1'b1)
        (push & ~pop): count <= count + 1'b1;
        (pop & ~push): count <= count - 1'b1;
        default:       count <= count;
      endcase
      if (imem_req) begin
        req_pc      <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
        outstanding <= 1'b1;
      end else if (resp) begin
        outstanding <= 1'b0;
      end
      if (resp) stale <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) q[tail] <= '{pc: req_pc, inst: imem_rdata};
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: random memory latency, decode stalls,
// redirects, resets and stray responses against an in-order fetch-stream model.
module tb_if_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .RESET_PC(RPC),
    .QUEUE_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_pc(id_pc),
    .id_inst(id_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  int n_chk = 0;
  int n_fail = 0;
  int pops = 0;
  logic [31:0] last_pc = '0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a | 32'hA000_0000;
  endfunction

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stimulus knobs
  int lat_min = 1, lat_max = 1;
  int rdy_pct = 100, redir_pct = 0, rst_pct = 0, stray_pct = 0;
  bit frc_rst = 0, frc_redir = 0, frc_stray = 0;
  logic [31:0] frc_pc = '0;

  // Memory model: one pending read with a countdown
  bit mp = 0;
  bit busy = 0;
  logic [31:0] ma = '0;
  int mc = 0;

  task automatic step();
    @(negedge clk);
    rst = !(frc_rst || ($urandom_range(99) < rst_pct));
    redirect_valid = frc_redir || ($urandom_range(99) < redir_pct);
    redirect_pc = frc_redir ? frc_pc : $urandom;
    id_ready = ($urandom_range(99) < rdy_pct);
    busy = mp;
    imem_rvalid = 1'b0;
    imem_rdata = $urandom;
    if (mp) begin
      if (mc <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata = memf(ma);
        mp = 0;
      end else begin
        mc--;
      end
    end else if (frc_stray || ($urandom_range(99) < stray_pct)) begin
      imem_rvalid = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
    end
    if (!rst) mp = 0;
    #1;
    if (imem_req) begin
      mp = 1;
      ma = imem_addr;
      mc = $urandom_range(lat_max, lat_min);
    end
  endtask

  // Reference model + monitor
  ent_t exp_q[$];
  logic [31:0] iss_pc = RPC;
  bit hold = 0;
  logic [31:0] hpc, hinst;

  always @(negedge clk) begin
    ent_t e;
    #2;
    if (!rst || redirect_valid)
      chk(!imem_req, "req_blocked", {31'b0, imem_req}, 32'd0);
    if (busy && !imem_rvalid)
      chk(!imem_req, "one_outstanding", {31'b0, imem_req}, 32'd0);
    if (imem_req)
      chk(imem_addr == iss_pc, "imem_addr", imem_addr, iss_pc);
    if (!id_valid)
      chk(id_pc == '0 && id_inst == NOP, "empty_out", id_inst, NOP);
    if (hold)
      chk(id_valid && id_pc == hpc && id_inst == hinst, "stable", id_pc, hpc);
    if (id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "sb_underflow", id_pc, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk(id_pc == e.pc, "sb_pc", id_pc, e.pc);
        chk(id_inst == e.inst, "sb_inst", id_inst, e.inst);
      end
      pops++;
      last_pc = id_pc;
    end
    hold = rst && !redirect_valid && id_valid && !id_ready;
    hpc = id_pc;
    hinst = id_inst;
    if (!rst) begin
      exp_q.delete();
      iss_pc = RPC;
    end else if (redirect_valid) begin
      exp_q.delete();
      iss_pc = redirect_pc & ~32'h3;
    end else if (imem_req) begin
      exp_q.push_back('{pc: iss_pc, inst: memf(iss_pc)});
      iss_pc = iss_pc + 32'd4;
    end
  end

  task automatic do_reset();
    frc_rst = 1;
    step();
    step();
    frc_rst = 0;
  endtask

  task automatic wait_pop(input string name, input logic [31:0] want);
    int mark;
    bit got;
    #2;
    mark = pops;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      #2;
      if (pops > mark) got = 1;
    end
    chk(got && last_pc == want, name, last_pc, want);
  endtask

  task automatic wait_issue(input string name, input logic [31:0] a);
    bit got;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      if (imem_req && imem_addr == a) got = 1;
    end
    chk(got, name, imem_addr, a);
  endtask

  initial begin
    int p0;
    rst = 0;
    id_ready = 0;
    imem_rvalid = 0;
    imem_rdata = '0;
    redirect_valid = 0;
    redirect_pc = '0;

    // Reset values and single-cycle streaming
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    do_reset();
    step();
    chk(!id_valid, "rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk(id_pc == '0, "rst_id_pc", id_pc, 32'd0);
    chk(id_inst == NOP, "rst_id_inst", id_inst, NOP);
    chk(imem_req, "rst_imem_req", {31'b0, imem_req}, 32'd1);
    chk(imem_addr == RPC, "rst_imem_addr", imem_addr, RPC);
    p0 = pops;
    repeat (11) step();
    #3;
    chk(pops - p0 == 10, "stream_rate", pops - p0, 32'd10);

    // Decode stalled: queue fills, fetch stops, then drains gaplessly
    rdy_pct = 0;
    do_reset();
    repeat (8) step();
    chk(!imem_req, "full_no_req", {31'b0, imem_req}, 32'd0);
    chk(id_valid && id_pc == RPC, "full_head", id_pc, RPC);
    rdy_pct = 100;
    #3;
    p0 = pops;
    repeat (3) step();
    #3;
    chk(pops - p0 == 3, "drain_no_gap", pops - p0, 32'd3);

    // Redirect while 0x8 in flight on a 3-cycle memory
    lat_min = 3; lat_max = 3;
    do_reset();
    wait_issue("issue_0x8", 32'h8);
    frc_redir = 1; frc_pc = 32'h100;
    step();
    frc_redir = 0;
    wait_pop("redir_first", 32'h100);

    // Misaligned redirect target
    frc_redir = 1; frc_pc = 32'h103;
    step();
    frc_redir = 0;
    step();
    chk(imem_addr == 32'h100, "align_addr", imem_addr, 32'h100);
    wait_pop("align_pop", 32'h100);

    // Reset with a full queue, late response pulse after reset
    lat_min = 1; lat_max = 1; rdy_pct = 0;
    repeat (8) step();
    frc_rst = 1;
    step();
    frc_rst = 0; frc_stray = 1;
    step();
    frc_stray = 0;
    chk(!id_valid, "midrst_valid", {31'b0, id_valid}, 32'd0);
    chk(imem_addr == RPC, "midrst_addr", imem_addr, RPC);
    rdy_pct = 100;
    wait_pop("midrst_pop", RPC);

    // Stray response with nothing outstanding (queue full)
    rdy_pct = 0;
    repeat (8) step();
    frc_stray = 1;
    step();
    frc_stray = 0;
    step();
    chk(!imem_req, "stray_no_req", {31'b0, imem_req}, 32'd0);
    rdy_pct = 100;
    repeat (6) step();

    // Stray response during a held redirect
    frc_redir = 1; frc_pc = 32'h40;
    repeat (3) step();
    frc_stray = 1;
    step();
    frc_stray = 0; frc_redir = 0;
    chk(!id_valid, "stray_redir", {31'b0, id_valid}, 32'd0);

    // Fetch PC wrap
    frc_redir = 1; frc_pc = 32'hFFFF_FFFC;
    step();
    frc_redir = 0;
    wait_issue("issue_top", 32'hFFFF_FFFC);
    step();
    chk(imem_addr == 32'h0, "wrap_addr", imem_addr, 32'h0);

    // Random soak
    lat_min = 1; lat_max = 3;
    rdy_pct = 70; redir_pct = 4; rst_pct = 1; stray_pct = 3;
    #3;
    p0 = pops;
    repeat (4000) step();
    #3;
    chk(pops - p0 > 300, "throughput", pops - p0, 32'd300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
